// File: rtl/stack_decode_pipe.sv
// -----------------------------------------------------------------------------
// stack_decode_pipe
//   Control unit front end for the stack CPU. It accepts one instruction per
//   cycle from fetch over a valid/ready handshake. It decodes the instruction
//   into registered datapath controls and holds them stable while the datapath
//   stalls. It tracks data-stack occupancy so that overflow and underflow are
//   caught before an instruction issues. A RUN/HALT/FAULT sequencer gates
//   acceptance.
//
//   Instruction bit 0 is the MSB ([0:N] ordering), giving this field layout:
//     [0] J (0 = ALU, 1 = jump)   [1:2] SP action (hold/push/pop/pop2)
//     [3] stack write             [4:8] ALU op   [9] R write
//     [10:11] jSel                [12:INSTR_W-1] jCtrl
//   The all-ones instruction is HALT.
//
// Ports
//   i_clk, i_rst        clock; synchronous active-high reset
//   i_instr_valid       fetch presents i_instruction
//   o_instr_ready       decoder accepts this cycle (combinational)
//   i_instruction       instruction word, [0:INSTR_W-1]
//   i_stall             datapath cannot take new controls
//   i_resume            leave HALT
//   o_ctrl_valid        registered controls are valid
//   o_stkWCtrl .. o_jCtrl  registered decode
//   o_sp                data-stack occupancy
//   o_halted, o_fault   sequencer state
//   o_fault_code        01 overflow, 10 underflow, 00 none
// -----------------------------------------------------------------------------
module stack_decode_pipe #(
    parameter int INSTR_W   = 18,
    parameter int STK_DEPTH = 16,
    localparam int SP_W     = $clog2(STK_DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_instr_valid,
    output logic                  o_instr_ready,
    input  logic [0:INSTR_W-1]    i_instruction,
    input  logic                  i_stall,
    input  logic                  i_resume,
    output logic                  o_ctrl_valid,
    output logic                  o_stkWCtrl,
    output logic                  o_stkSCtrl,
    output logic                  o_RWCtrl,
    output logic                  o_TWCtrl,
    output logic                  o_carryWCtrl,
    output logic [4:0]            o_instrOP,
    output logic [1:0]            o_jSelCtrl,
    output logic [INSTR_W-13:0]   o_jCtrl,
    output logic [SP_W-1:0]       o_sp,
    output logic                  o_halted,
    output logic                  o_fault,
    output logic [1:0]            o_fault_code
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HALT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    typedef struct packed {
        logic                stk_w;
        logic                stk_s;
        logic                r_w;
        logic                t_w;
        logic                carry_w;
        logic [4:0]          op;
        logic [1:0]          jsel;
        logic [INSTR_W-13:0] jctrl;
    } ctrl_t;

    localparam logic [1:0] ACT_HOLD = 2'b00;
    localparam logic [1:0] ACT_PUSH = 2'b01;
    localparam logic [1:0] ACT_POP  = 2'b10;
    localparam logic [1:0] ACT_POP2 = 2'b11;

    state_t          state;
    state_t          state_nxt;
    ctrl_t           ctrl_q;
    ctrl_t           dec;
    logic            ctrl_valid;
    logic [SP_W-1:0] sp;
    logic [SP_W-1:0] sp_nxt;
    logic [1:0]      fault_code;

    logic [1:0]      act;
    logic            ready;
    logic            accept;
    logic            is_halt;
    logic            ovf;
    logic            unf;
    logic            fault_hit;
    logic            issue;
    logic            sp_lt2;

    // ---------------------------------------------------------------------
    // Handshake and hazard checks
    // ---------------------------------------------------------------------
    assign act     = i_instruction[1:2];
    assign is_halt = &i_instruction;

    // A stalled, valid control word blocks acceptance so the held controls
    // are never overwritten.
    assign ready  = ~i_rst & (state == S_RUN) & (~ctrl_valid | ~i_stall);
    assign accept = i_instr_valid & ready;

    // Written without a literal 2 so the compare stays correct for tiny SP_W.
    assign sp_lt2 = (sp == '0) | (sp == SP_W'(1));

    assign ovf = (act == ACT_PUSH) & (sp == SP_W'(STK_DEPTH));
    assign unf = ((act == ACT_POP) & (sp == '0)) | ((act == ACT_POP2) & sp_lt2);

    // HALT takes precedence: it carries a pop2 pattern but never touches
    // the stack, so it must not raise an underflow.
    assign fault_hit = ~is_halt & (ovf | unf);
    assign issue     = accept & ~is_halt & ~fault_hit;

    always_comb begin
        sp_nxt = sp;
        case (act)
            ACT_PUSH: sp_nxt = sp + SP_W'(1);
            ACT_POP:  sp_nxt = sp - SP_W'(1);
            ACT_POP2: sp_nxt = sp - SP_W'(2);
            default:  sp_nxt = sp;
        endcase
    end

    // ---------------------------------------------------------------------
    // Decode
    // ---------------------------------------------------------------------
    always_comb begin
        dec       = '0;
        dec.stk_s = (act != ACT_HOLD);
        if (!i_instruction[0]) begin
            dec.stk_w   = i_instruction[3];
            dec.r_w     = i_instruction[9];
            dec.t_w     = 1'b1;
            dec.carry_w = i_instruction[4];
            dec.op      = i_instruction[4:8];
        end else begin
            // Jump class keeps only the SP step (call/return) plus the jump fields.
            dec.jsel  = i_instruction[10:11];
            dec.jctrl = i_instruction[12:INSTR_W-1];
        end
    end

    // ---------------------------------------------------------------------
    // Sequencer
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (accept && is_halt)        state_nxt = S_HALT;
                else if (accept && fault_hit) state_nxt = S_FAULT;
            end
            S_HALT:  if (i_resume) state_nxt = S_RUN;
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_RUN;
        endcase
    end

    // ---------------------------------------------------------------------
    // Control registers, stack pointer, fault code
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ctrl_q     <= '0;
            ctrl_valid <= 1'b0;
            sp         <= '0;
            fault_code <= 2'b00;
        end else begin
            // Under stall everything holds. Otherwise the registers either load
            // a fresh decode or clear to zero, so idle cycles present no stale controls.
            if (!(ctrl_valid && i_stall)) begin
                ctrl_q     <= issue ? dec : '0;
                ctrl_valid <= issue;
            end
            if (issue) sp <= sp_nxt;
            if (accept && fault_hit) fault_code <= ovf ? 2'b01 : 2'b10;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign o_instr_ready = ready;
    assign o_ctrl_valid  = ctrl_valid;
    assign o_stkWCtrl    = ctrl_q.stk_w;
    assign o_stkSCtrl    = ctrl_q.stk_s;
    assign o_RWCtrl      = ctrl_q.r_w;
    assign o_TWCtrl      = ctrl_q.t_w;
    assign o_carryWCtrl  = ctrl_q.carry_w;
    assign o_instrOP     = ctrl_q.op;
    assign o_jSelCtrl    = ctrl_q.jsel;
    assign o_jCtrl       = ctrl_q.jctrl;
    assign o_sp          = sp;
    assign o_halted      = (state == S_HALT);
    assign o_fault       = (state == S_FAULT);
    assign o_fault_code  = fault_code;

endmodule

// File: tb/tb_stack_decode_pipe.sv
// -----------------------------------------------------------------------------
// tb_stack_decode_pipe
//   Directed scenarios plus randomized traffic for stack_decode_pipe. The
//   expected outputs come from a cycle model that works on instruction fields
//   and on stack occupancy as a plain integer range.
// -----------------------------------------------------------------------------
module tb_stack_decode_pipe;
    localparam int W   = 18;
    localparam int D   = 16;
    localparam int SPW = 5;
    localparam int JW  = W - 12;
    localparam int OW  = 1 + 5 + 5 + 2 + JW + SPW + 4;

    logic          clk = 1'b0;
    logic          rst, ivalid, stall, resume;
    logic [W-1:0]  instr;
    logic          o_instr_ready, o_ctrl_valid, o_stkWCtrl, o_stkSCtrl, o_RWCtrl;
    logic          o_TWCtrl, o_carryWCtrl, o_halted, o_fault;
    logic [4:0]    o_instrOP;
    logic [1:0]    o_jSelCtrl, o_fault_code;
    logic [JW-1:0] o_jCtrl;
    logic [SPW-1:0] o_sp;

    stack_decode_pipe #(.INSTR_W(W), .STK_DEPTH(D)) dut (
        .i_clk(clk), .i_rst(rst), .i_instr_valid(ivalid), .o_instr_ready(o_instr_ready),
        .i_instruction(instr), .i_stall(stall), .i_resume(resume),
        .o_ctrl_valid(o_ctrl_valid), .o_stkWCtrl(o_stkWCtrl), .o_stkSCtrl(o_stkSCtrl),
        .o_RWCtrl(o_RWCtrl), .o_TWCtrl(o_TWCtrl), .o_carryWCtrl(o_carryWCtrl),
        .o_instrOP(o_instrOP), .o_jSelCtrl(o_jSelCtrl), .o_jCtrl(o_jCtrl), .o_sp(o_sp),
        .o_halted(o_halted), .o_fault(o_fault), .o_fault_code(o_fault_code)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: 0 = RUN, 1 = HALT, 2 = FAULT.
    int            m_sp, m_st;
    logic          m_valid, m_sw, m_ss, m_rw, m_tw, m_cw;
    logic [4:0]    m_op;
    logic [1:0]    m_js, m_code;
    logic [JW-1:0] m_jc;

    localparam logic [W-1:0] PUSH = 18'b0_01_0_00000_0_00_000000;
    localparam logic [W-1:0] POP2 = 18'b0_11_0_00000_0_00_000000;

    // Field [a:b] in MSB-is-bit-0 numbering.
    function automatic int fld(logic [W-1:0] ins, int a, int b);
        return int'((ins >> (W - 1 - b)) & W'((1 << (b - a + 1)) - 1));
    endfunction

    function automatic logic [OW-1:0] obs();
        return {o_ctrl_valid, o_stkWCtrl, o_stkSCtrl, o_RWCtrl, o_TWCtrl, o_carryWCtrl,
                o_instrOP, o_jSelCtrl, o_jCtrl, o_sp, o_halted, o_fault, o_fault_code};
    endfunction

    function automatic logic [OW-1:0] exp_v();
        return {m_valid, m_sw, m_ss, m_rw, m_tw, m_cw, m_op, m_js, m_jc,
                SPW'(m_sp), m_st == 1, m_st == 2, m_code};
    endfunction

    function automatic logic exp_ready();
        return !rst && m_st == 0 && (!m_valid || !stall);
    endfunction

    task automatic clear_ctrl();
        m_valid = 0; m_sw = 0; m_ss = 0; m_rw = 0; m_tw = 0; m_cw = 0;
        m_op = '0; m_js = '0; m_jc = '0;
    endtask

    // Advance the model by one rising edge using the current inputs.
    task automatic model_edge();
        logic acc, issue;
        int   act, delta;
        if (rst) begin
            clear_ctrl(); m_sp = 0; m_st = 0; m_code = 0;
            return;
        end
        acc   = ivalid && exp_ready();
        issue = 0;
        act   = fld(instr, 1, 2);
        delta = (act == 1) ? 1 : (act == 2) ? -1 : (act == 3) ? -2 : 0;
        if (acc) begin
            if (&instr)                  m_st = 1;
            else if (m_sp + delta > D) begin m_st = 2; m_code = 2'b01; end
            else if (m_sp + delta < 0) begin m_st = 2; m_code = 2'b10; end
            else                         issue = 1;
        end else if (m_st == 1 && resume) begin
            m_st = 0;
        end
        if (m_valid && stall) begin
            // controls hold
        end else if (issue) begin
            clear_ctrl();
            m_valid = 1;
            m_ss = (act != 0);
            if (fld(instr, 0, 0) == 0) begin
                m_sw = 1'(fld(instr, 3, 3));
                m_rw = 1'(fld(instr, 9, 9));
                m_tw = 1;
                m_cw = 1'(fld(instr, 4, 4));
                m_op = 5'(fld(instr, 4, 8));
            end else begin
                m_js = 2'(fld(instr, 10, 11));
                m_jc = JW'(fld(instr, 12, W - 1));
            end
            m_sp = m_sp + delta;
        end else begin
            clear_ctrl();
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; ivalid = 0; stall = 0; resume = 0; instr = '0;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; ivalid = 1; stall = 0; resume = 0; instr = PUSH;
        tick(); tick();
        if (obs() !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", obs()); end
        n_cmp++;
        if (o_instr_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_low: got %b want 0", o_instr_ready); end
        n_cmp++;
        rst = 0; ivalid = 0; #1;
        if (o_instr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_high: got %b want 1", o_instr_ready); end
        n_cmp++;
    endtask

    task automatic test_alu_push();
        instr = 18'b0_01_1_10110_1_00_000000; ivalid = 1;
        tick();
        ivalid = 0;
        if ({o_ctrl_valid, o_stkWCtrl, o_stkSCtrl, o_RWCtrl, o_TWCtrl, o_carryWCtrl, o_instrOP, o_sp}
            !== {6'b111111, 5'b10110, 5'd1}) begin
            n_bad++; $display("FAIL alu_push_fields: got v%b w%b s%b r%b t%b c%b op%b sp%0d want all 1 op 10110 sp 1",
                o_ctrl_valid, o_stkWCtrl, o_stkSCtrl, o_RWCtrl, o_TWCtrl, o_carryWCtrl, o_instrOP, o_sp);
        end
        n_cmp++;
        if (obs() !== exp_v()) begin n_bad++; $display("FAIL alu_push_model: got %h want %h", obs(), exp_v()); end
        n_cmp++;
        tick();
        if (o_ctrl_valid !== 1'b0 || o_instrOP !== 5'd0 || o_sp !== 5'd1) begin
            n_bad++; $display("FAIL alu_idle_clear: got v%b op%b sp%0d want v0 op0 sp1", o_ctrl_valid, o_instrOP, o_sp);
        end
        n_cmp++;
    endtask

    task automatic test_jump_stall();
        instr = 18'b1_00_0_00000_0_10_101011; ivalid = 1; stall = 0;
        tick();
        instr = PUSH; stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (o_instr_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready%0d: got %b want 0", i, o_instr_ready); end
            n_cmp++;
            tick();
            if (o_ctrl_valid !== 1'b1 || o_jSelCtrl !== 2'b10 || o_jCtrl !== 6'b101011 || o_TWCtrl !== 1'b0) begin
                n_bad++; $display("FAIL stall_hold%0d: got v%b jsel%b jc%b t%b want v1 jsel10 jc101011 t0",
                    i, o_ctrl_valid, o_jSelCtrl, o_jCtrl, o_TWCtrl);
            end
            n_cmp++;
            if (obs() !== exp_v()) begin n_bad++; $display("FAIL stall_model%0d: got %h want %h", i, obs(), exp_v()); end
            n_cmp++;
        end
        stall = 0; ivalid = 0; #1;
        if (o_instr_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release_ready: got %b want 1", o_instr_ready); end
        n_cmp++;
        tick();
    endtask

    task automatic test_overflow();
        do_reset();
        instr = PUSH; ivalid = 1;
        for (int i = 0; i < D; i++) begin
            tick();
            if (obs() !== exp_v()) begin n_bad++; $display("FAIL push_model%0d: got %h want %h", i, obs(), exp_v()); end
            n_cmp++;
        end
        tick();
        if (o_sp !== 5'd16 || o_fault !== 1'b1 || o_fault_code !== 2'b01 || o_ctrl_valid !== 1'b0) begin
            n_bad++; $display("FAIL overflow: got sp%0d f%b code%b v%b want sp16 f1 code01 v0",
                o_sp, o_fault, o_fault_code, o_ctrl_valid);
        end
        n_cmp++;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (o_instr_ready !== 1'b0) begin n_bad++; $display("FAIL fault_ready%0d: got %b want 0", i, o_instr_ready); end
            n_cmp++;
            resume = 1;
            tick();
            resume = 0;
            if (o_fault !== 1'b1 || o_sp !== 5'd16) begin
                n_bad++; $display("FAIL fault_sticky%0d: got f%b sp%0d want f1 sp16", i, o_fault, o_sp);
            end
            n_cmp++;
        end
    endtask

    task automatic test_underflow();
        do_reset();
        instr = PUSH; ivalid = 1;
        tick();
        instr = POP2;
        tick();
        if (o_fault_code !== 2'b10 || o_sp !== 5'd1 || o_fault !== 1'b1 || o_ctrl_valid !== 1'b0) begin
            n_bad++; $display("FAIL underflow: got code%b sp%0d f%b v%b want code10 sp1 f1 v0",
                o_fault_code, o_sp, o_fault, o_ctrl_valid);
        end
        n_cmp++;
        ivalid = 0; rst = 1; #1;
        if (o_instr_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_low: got %b want 0", o_instr_ready); end
        n_cmp++;
        tick();
        rst = 0; #1;
        if (obs() !== '0 || o_instr_ready !== 1'b1) begin
            n_bad++; $display("FAIL fault_reset: got %h rdy%b want 0 rdy1", obs(), o_instr_ready);
        end
        n_cmp++;
    endtask

    task automatic test_halt();
        instr = '1; ivalid = 1;
        tick();
        if (o_halted !== 1'b1 || o_ctrl_valid !== 1'b0 || o_sp !== 5'd0) begin
            n_bad++; $display("FAIL halt_enter: got h%b v%b sp%0d want h1 v0 sp0", o_halted, o_ctrl_valid, o_sp);
        end
        n_cmp++;
        instr = PUSH;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (o_instr_ready !== 1'b0) begin n_bad++; $display("FAIL halt_ready%0d: got %b want 0", i, o_instr_ready); end
            n_cmp++;
            tick();
        end
        ivalid = 0; resume = 1;
        tick();
        resume = 0;
        if (o_halted !== 1'b0) begin n_bad++; $display("FAIL halt_resume: got h%b want 0", o_halted); end
        n_cmp++;
        ivalid = 1;
        tick();
        ivalid = 0;
        if (o_ctrl_valid !== 1'b1 || o_sp !== 5'd1) begin
            n_bad++; $display("FAIL halt_push: got v%b sp%0d want v1 sp1", o_ctrl_valid, o_sp);
        end
        n_cmp++;
        tick();
    endtask

    task automatic test_back_to_back();
        int act;
        do_reset();
        ivalid = 1;
        for (int i = 0; i < 24; i++) begin
            act = int'($urandom_range(0, 3));
            if (act == 1 && m_sp >= D) act = 2;
            if (act == 2 && m_sp < 1) act = 1;
            if (act == 3 && m_sp < 2) act = 1;
            instr = W'($urandom);
            instr[W-2 -: 2] = 2'(act);
            if (&instr) instr[0] = 1'b0;
            tick();
            if (o_ctrl_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid%0d: got %b want 1", i, o_ctrl_valid); end
            n_cmp++;
            if (obs() !== exp_v()) begin n_bad++; $display("FAIL b2b_model%0d: got %h want %h", i, obs(), exp_v()); end
            n_cmp++;
        end
        ivalid = 0;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 99) == 0) || (m_st == 2 && $urandom_range(0, 7) == 0);
            ivalid = ($urandom_range(0, 3) != 0);
            stall  = ($urandom_range(0, 2) == 0);
            resume = ($urandom_range(0, 5) == 0);
            instr  = W'($urandom);
            if ($urandom_range(0, 1) == 1) instr[W-2 -: 2] = 2'b01;
            if ($urandom_range(0, 24) == 0) instr = '1;
            #1;
            if (o_instr_ready !== exp_ready()) begin
                n_bad++; $display("FAIL rand_ready%0d: got %b want %b", i, o_instr_ready, exp_ready());
            end
            n_cmp++;
            tick();
            if (obs() !== exp_v()) begin n_bad++; $display("FAIL rand_model%0d: got %h want %h", i, obs(), exp_v()); end
            n_cmp++;
        end
        rst = 0; ivalid = 0; stall = 0; resume = 0;
    endtask

    initial begin
        m_sp = 0; m_st = 0; m_code = 0;
        clear_ctrl();
        rst = 1; ivalid = 0; stall = 0; resume = 0; instr = '0;
        test_reset();
        test_alu_push();
        test_jump_stall();
        test_overflow();
        test_underflow();
        test_halt();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/stack_decode_pipe.md
Name: stack_decode_pipe

Overview:
- Next-generation control unit for the stack CPU.
- Registers the instruction decode behind a valid/ready handshake and holds the decoded controls stable under downstream stall.
- Tracks the data-stack pointer and detects overflow and underflow before issue.
- Adds a RUN/HALT/FAULT sequencer. Sits between instruction fetch and the datapath (stack, R, T, ALU, jump unit).

Parameters:
- INSTR_W, 18, instruction width; must be at least 13. The jump-control field width is INSTR_W-12.
- STK_DEPTH, 16, data-stack entries. o_sp width SP_W = $clog2(STK_DEPTH+1), a local derived value.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  reset, synchronous and active-high.
- i_instr_valid  in  1  fetch presents an instruction.
- o_instr_ready  out  1  decoder accepts this cycle.
- i_instruction  in  INSTR_W  instruction; bit 0 is the MSB, the codebase's [0:N] ordering.
- i_stall  in  1  datapath cannot take new controls.
- i_resume  in  1  leave HALT.
- o_ctrl_valid  out  1  registered controls below are valid.
- o_stkWCtrl  out  1  stack write.
- o_stkSCtrl  out  1  stack pointer step.
- o_RWCtrl  out  1  R write.
- o_TWCtrl  out  1  T write.
- o_carryWCtrl  out  1  carry write.
- o_instrOP  out  5  ALU op.
- o_jSelCtrl  out  2  jump select.
- o_jCtrl  out  INSTR_W-12  jump control.
- o_sp  out  SP_W  stack occupancy.
- o_halted  out  1  state is HALT.
- o_fault  out  1  state is FAULT.
- o_fault_code  out  2  01 = overflow, 10 = underflow, 00 = none.

Behaviour:
- Field layout:
  - [0] J: 0 = ALU class, 1 = jump class.
  - [1:2] SP action: 00 hold, 01 push (+1), 10 pop (-1), 11 pop2 (-2).
  - [3] stack write.
  - [4:8] op.
  - [9] R write.
  - [10:11] jSel.
  - [12:INSTR_W-1] jCtrl.
- HALT instruction is all bits 1.
- ALU-class decode (J=0):
  - stkWCtrl = [3]; stkSCtrl = (SP action != 00); RWCtrl = [9].
  - TWCtrl = 1; carryWCtrl = [4]; instrOP = [4:8].
  - jSelCtrl = 0 and jCtrl = 0.
- Jump-class decode (J=1):
  - stkWCtrl, RWCtrl, TWCtrl, carryWCtrl and instrOP are all 0.
  - stkSCtrl = (SP action != 00); jSelCtrl = [10:11]; jCtrl = [12:].
  - SP action is honoured, used for call and return.
- Handshake:
  - o_instr_ready = ~i_rst & (state==RUN) & (~o_ctrl_valid | ~i_stall). This is combinational.
  - Accept occurs when i_instr_valid & o_instr_ready.
- Issue (accept of a non-HALT, non-faulting instruction): next cycle, the control registers load the decode, o_ctrl_valid=1, and o_sp updates. Latency is 1 cycle.
- Stall: if o_ctrl_valid & i_stall, all control outputs and o_ctrl_valid hold.
- Idle: if there is no accept and no stall, o_ctrl_valid goes to 0 and the control registers clear to 0.
- Fault check against o_sp at accept:
  - Push with o_sp == STK_DEPTH: overflow.
  - Pop with o_sp < 1, or pop2 with o_sp < 2: underflow.
- On a fault:
  - The instruction is consumed but not issued; o_sp is unchanged.
  - State goes to FAULT, o_fault_code is set, and o_ctrl_valid goes to 0 unless stall is holding a prior issue.
- FSM:
  - RUN -> HALT on accept of the HALT instruction, which is not issued.
  - RUN -> FAULT on a faulting accept.
  - HALT -> RUN when i_resume=1 (one cycle); i_resume in RUN or FAULT is ignored.
  - FAULT is sticky until i_rst.
- o_sp wrap-around cannot occur; fault detection blocks it.
- Reset (any cycle, including mid-stall or HALT):
  - Next edge: state RUN; all outputs 0, including o_sp, o_ctrl_valid, o_fault, o_fault_code and o_halted.
  - o_instr_ready is 0 while i_rst=1.

Test Plan:
- Reset, then ALU push 18'b0_01_1_10110_1_00_000000 valid for 1 cycle -> next cycle: o_ctrl_valid=1, stkWCtrl=1, stkSCtrl=1, RWCtrl=1, TWCtrl=1, carryWCtrl=1, instrOP=10110, o_sp=1.
- Jump 18'b1_00_0_00000_0_10_101011 with i_stall=1 held 3 cycles after issue -> jSelCtrl=10 and jCtrl=101011 stable and o_instr_ready=0 throughout; ready returns 1 the cycle i_stall drops.
- 16 pushes then a 17th push (STK_DEPTH=16) -> o_sp=16, o_fault=1, o_fault_code=01, 17th not issued, o_instr_ready=0 until reset.
- From o_sp=1, pop2 -> o_fault_code=10, o_sp stays 1. Assert i_rst -> next cycle all outputs 0 and ready=1.
- All-ones instruction -> o_halted=1, no issue, ready=0 for 5 cycles. Pulse i_resume -> RUN; the next push issues with o_sp incremented.
- Back-to-back valid instructions with no stall -> one issue per cycle; o_ctrl_valid continuously 1; o_sp tracks the cumulative delta.
